// File: rtl/image_loader.sv
// ---------------------------------------------------------------------------
// image_loader
//
// Captures one grayscale source frame of (picture_size*DS) x (picture_size*DS)
// pixels, box-averages it down to picture_size x picture_size, and writes the
// averaged pixels into the network's input database. When the last database
// word has been written, it pulses GO once. It then waits for the network to
// finish: STOP must be seen low and then high again.
//
// Configuration macro:
//   IMAGE_LOADER_INVERT_EN - when defined, the written pixel is 255 - average
//                            (white-on-black polarity). When undefined, the
//                            average is written unchanged.
//
// Assumes DS is a power of two and DS >= 2.
//
// Ports:
//   clk                 in   sole clock, rising edge
//   rst                 in   synchronous active-high reset
//   pix_valid           in   source pixel qualifier (gaps allowed)
//   pix_sof             in   first pixel of a frame (qualified by pix_valid)
//   pix_data     [7:0]  in   unsigned grayscale pixel, raster order
//   STOP                in   network done flag (0 running, 1 result valid)
//   we_database         out  database write strobe
//   dp_database  [S-1:0] out signed pixel word (always 0..255)
//   address_p_database [12:0] out  database word address
//   GO                  out  one-cycle network start pulse
//   busy                out  high whenever the FSM is not in IDLE
//   frames_dropped [7:0] out saturating count of discarded frames
//
// Handshake: a source pixel is consumed on every rising edge where pix_valid
// is 1. There is no back-pressure. Pixels are ignored once a frame is complete
// and until the FSM is back in IDLE.
// ---------------------------------------------------------------------------
module image_loader #(
    parameter int SIZE_1       = 11,
    parameter int picture_size = 28,
    parameter int DS           = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [7:0]        pix_data,
    input  logic              STOP,
    output logic              we_database,
    output logic [SIZE_1-1:0] dp_database,
    output logic [12:0]       address_p_database,
    output logic              GO,
    output logic              busy,
    output logic [7:0]        frames_dropped
);

    localparam int SRC    = picture_size * DS;
    localparam int LOG2DS = $clog2(DS);
    localparam int ACC_W  = 8 + 2 * LOG2DS;
    localparam int CW     = $clog2(SRC);
    localparam int BW     = CW - LOG2DS;

    typedef enum logic [1:0] {IDLE, CAPTURE, START, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    col_q, row_q;
    logic [ACC_W-1:0] acc [picture_size];
    logic             seen_low;
    logic             frame_done;

    // A start-of-frame pixel is always treated as source (0,0), both when a
    // capture begins from IDLE and when a capture is restarted.
    logic [CW-1:0]    cur_col, cur_row;
    logic [BW-1:0]    col_blk, row_blk;
    logic             blk_first, blk_last, frame_last;
    logic [ACC_W-1:0] acc_prev, blk_sum;
    logic [7:0]       blk_avg, dp_val;
    logic [12:0]      addr_calc;
    logic             accept, drop;

    assign cur_col = pix_sof ? '0 : col_q;
    assign cur_row = pix_sof ? '0 : row_q;
    assign col_blk = cur_col[CW-1:LOG2DS];
    assign row_blk = cur_row[CW-1:LOG2DS];

    assign blk_first  = (cur_col[LOG2DS-1:0] == '0) && (cur_row[LOG2DS-1:0] == '0);
    assign blk_last   = (&cur_col[LOG2DS-1:0]) && (&cur_row[LOG2DS-1:0]);
    assign frame_last = (cur_col == CW'(SRC - 1)) && (cur_row == CW'(SRC - 1));

    // The first pixel of each block overwrites its accumulator. This clears
    // the accumulators at the start of every DS-row band, and also on a
    // restart, without needing a separate clear pass.
    assign acc_prev = blk_first ? '0 : acc[col_blk];
    assign blk_sum  = acc_prev + ACC_W'(pix_data);
    assign blk_avg  = blk_sum[ACC_W-1:2*LOG2DS];

`ifdef IMAGE_LOADER_INVERT_EN
    assign dp_val = 8'd255 - blk_avg;
`else
    assign dp_val = blk_avg;
`endif

    assign addr_calc = 13'(int'(row_blk) * picture_size + int'(col_blk));

    assign accept = pix_valid &&
                    ((state == IDLE && pix_sof) || (state == CAPTURE && !frame_done));
    assign drop   = pix_valid && pix_sof && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            col_q              <= '0;
            row_q              <= '0;
            seen_low           <= 1'b0;
            frame_done         <= 1'b0;
            we_database        <= 1'b0;
            dp_database        <= '0;
            address_p_database <= '0;
            GO                 <= 1'b0;
            busy               <= 1'b0;
            frames_dropped     <= '0;
            for (int i = 0; i < picture_size; i++) acc[i] <= '0;
        end else begin
            we_database <= 1'b0;
            GO          <= 1'b0;

            if (drop && frames_dropped != 8'hFF)
                frames_dropped <= frames_dropped + 8'd1;

            if (accept) begin
                acc[col_blk] <= blk_sum;
                if (cur_col == CW'(SRC - 1)) begin
                    col_q <= '0;
                    row_q <= cur_row + CW'(1);
                end else begin
                    col_q <= cur_col + CW'(1);
                    row_q <= cur_row;
                end
                frame_done <= frame_last;
                if (blk_last) begin
                    we_database        <= 1'b1;
                    dp_database        <= SIZE_1'(dp_val);
                    address_p_database <= addr_calc;
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= CAPTURE;
                        busy  <= 1'b1;
                    end
                end
                // frame_done is high during the cycle that carries the final
                // write. GO therefore follows that write by exactly one cycle.
                CAPTURE: begin
                    if (frame_done) begin
                        state      <= START;
                        GO         <= 1'b1;
                        frame_done <= 1'b0;
                    end
                end
                START: begin
                    state    <= RUN;
                    seen_low <= 1'b0;
                end
                // A STOP that is still high from the previous run must not
                // end this run. STOP has to be seen low first.
                RUN: begin
                    if (!STOP) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        seen_low <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_loader.sv
module tb_image_loader;

    localparam int SIZE_1 = 11;
    localparam int PS     = 28;
    localparam int DS     = 4;
    localparam int SRC    = PS * DS;
    localparam int NPIX   = SRC * SRC;
    localparam int NBLK   = PS * PS;

    localparam int K_UNI  = 0;
    localparam int K_RND  = 1;
    localparam int K_GRAD = 2;
    localparam int K_RAMP = 3;
    localparam int G_NONE = 0;
    localparam int G_TOG  = 1;

    logic              clk;
    logic              rst;
    logic              pix_valid;
    logic              pix_sof;
    logic [7:0]        pix_data;
    logic              STOP;
    logic              we_database;
    logic [SIZE_1-1:0] dp_database;
    logic [12:0]       address_p_database;
    logic              GO;
    logic              busy;
    logic [7:0]        frames_dropped;

    image_loader #(.SIZE_1(SIZE_1), .picture_size(PS), .DS(DS)) dut (
        .clk                (clk),
        .rst                (rst),
        .pix_valid          (pix_valid),
        .pix_sof            (pix_sof),
        .pix_data           (pix_data),
        .STOP               (STOP),
        .we_database        (we_database),
        .dp_database        (dp_database),
        .address_p_database (address_p_database),
        .GO                 (GO),
        .busy               (busy),
        .frames_dropped     (frames_dropped)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [55:0] exp_q[$];          // {cycle[31:0], addr[12:0], dp[10:0]}
    int n_tests = 0;
    int n_fail  = 0;
    int mdl_sum [NBLK];
    int wr_count, go_count, go_cyc;
    int first_wr_addr, first_wr_dp, first_wr_cyc;
    int last_exp_cyc, cyc_33;

    typedef struct {
        int kind;
        int base;
        int gap;
        int exp_writes;
        int exp_go;
    } vec_t;
    vec_t vecs [2];

    function automatic int exp_dp(input int sum);
        int avg;
        avg = sum / (DS * DS);
`ifdef IMAGE_LOADER_INVERT_EN
        return 255 - avg;
`else
        return avg;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic monitor_loop();
        logic [55:0] e;
        forever begin
            @(negedge clk);
            if (GO === 1'b1) begin
                go_count++;
                go_cyc = cyc;
            end
            if (we_database === 1'b1) begin
                wr_count++;
                if (wr_count == 1) begin
                    first_wr_addr = int'(address_p_database);
                    first_wr_dp   = int'(dp_database);
                    first_wr_cyc  = cyc;
                end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got addr=%0d dp=%0d at cycle %0d, expected no write",
                             address_p_database, dp_database, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({32'(cyc), address_p_database, dp_database} !== e) begin
                        n_fail++;
                        $display("FAIL write: got cyc=%0d addr=%0d dp=%0d, expected cyc=%0d addr=%0d dp=%0d",
                                 cyc, address_p_database, dp_database,
                                 e[55:24], e[23:11], e[10:0]);
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_cycle();
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic send_frame(input int kind, input int base, input int gap, input int npix);
        int r, c, blk;
        logic [7:0] p;
        for (int i = 0; i < npix; i++) begin
            r = i / SRC;
            c = i % SRC;
            case (kind)
                K_UNI:   p = 8'(base);
                K_RND:   p = 8'($urandom_range(0, 255));
                K_GRAD:  p = 8'((r + c) & 255);
                default: p = 8'(((r % DS) * DS + (c % DS)) * 16);
            endcase
            if (gap == G_TOG && i > 0) idle_cycle();
            @(posedge clk);
            #1;
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            pix_data  = p;
            blk = (r / DS) * PS + c / DS;
            if (r % DS == 0 && c % DS == 0) mdl_sum[blk] = 0;
            mdl_sum[blk] += int'(p);
            if (r == 3 && c == 3) cyc_33 = cyc;
            if (r % DS == DS - 1 && c % DS == DS - 1) begin
                exp_q.push_back({32'(cyc + 1), 13'(blk), 11'(exp_dp(mdl_sum[blk]))});
                last_exp_cyc = cyc + 1;
            end
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic finish_run(input string name);
        int k;
        @(posedge clk); #1; STOP = 1'b0;
        repeat (2) @(posedge clk);
        #1; STOP = 1'b1;
        k = 0;
        while (busy !== 1'b0 && k < 5) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic check_frame_end(input string name, input int writes, input int gos);
        repeat (10) @(negedge clk);
        check({name, "_writes"}, wr_count, writes);
        check({name, "_go_count"}, go_count, gos);
        check({name, "_go_cycle"}, go_cyc, last_exp_cyc + 1);
        check({name, "_busy"}, int'(busy), 1);
        check({name, "_addr_hold"}, int'(address_p_database), NBLK - 1);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{kind: K_UNI, base: 200, gap: G_TOG,  exp_writes: NBLK, exp_go: 1};
        vecs[1] = '{kind: K_RND, base: 0,   gap: G_NONE, exp_writes: NBLK, exp_go: 1};

        rst = 1'b1; STOP = 1'b1;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'd0;
        wr_count = 0; go_count = 0; go_cyc = -1;
        first_wr_addr = -1; first_wr_dp = -1; first_wr_cyc = -1;
        last_exp_cyc = 0; cyc_33 = 0;
        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        check("rst_we", int'(we_database), 0);
        check("rst_go", int'(GO), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dp", int'(dp_database), 0);
        check("rst_addr", int'(address_p_database), 0);
        check("rst_dropped", int'(frames_dropped), 0);

        // Full frames from the table.
        for (int v = 0; v < 2; v++) begin
            wr_count = 0; go_count = 0;
            send_frame(vecs[v].kind, vecs[v].base, vecs[v].gap, NPIX);
            check_frame_end($sformatf("vec%0d", v), vecs[v].exp_writes, vecs[v].exp_go);
            finish_run($sformatf("vec%0d_release", v));
        end

        // Block ramp in frame 1, restart at source pixel 5000, full frame 2.
        wr_count = 0; go_count = 0;
        send_frame(K_RAMP, 0, G_NONE, 5000);
        check("ramp_first_addr", first_wr_addr, 0);
        check("ramp_first_dp", first_wr_dp, exp_dp(120 * DS * DS));
        check("ramp_first_cycle", first_wr_cyc, cyc_33 + 1);
        check("ramp_no_go_yet", go_count, 0);
        check("ramp_dropped_before", int'(frames_dropped), 0);
        send_frame(K_GRAD, 0, G_NONE, NPIX);
        check_frame_end("restart", 308 + NBLK, 1);
        check("restart_dropped", int'(frames_dropped), 1);

        // Stale STOP, then low, then high. A sof during RUN is only counted.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; STOP = 1'b1;
            @(negedge clk);
            check($sformatf("stale_stop_busy%0d", i), int'(busy), 1);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            STOP      = 1'b0;
            pix_valid = (i == 4);
            pix_sof   = (i == 4);
            pix_data  = 8'd77;
        end
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0;
        STOP = 1'b1;
        @(negedge clk);
        check("stop_low_busy", int'(busy), 1);
        check("run_sof_dropped", int'(frames_dropped), 2);
        @(negedge clk);
        check("stop_high_idle", int'(busy), 0);

        // Reset in the cycle that writes address 400, then a clean frame of 200.
        wr_count = 0; go_count = 0;
        send_frame(K_UNI, 200, G_NONE, 59 * SRC + 35 + 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_writes", wr_count, 401);
        check("mid_rst_we", int'(we_database), 0);
        check("mid_rst_addr", int'(address_p_database), 0);
        check("mid_rst_dp", int'(dp_database), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_dropped", int'(frames_dropped), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_no_go", go_count, 0);
        check("mid_rst_queue", exp_q.size(), 0);
        wr_count = 0; go_count = 0;
        send_frame(K_UNI, 200, G_NONE, NPIX);
        check_frame_end("post_rst", NBLK, 1);
        check("post_rst_dp", int'(dp_database), exp_dp(200 * DS * DS));
        finish_run("post_rst_release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter SIZE_1, default 11, width of the signed pixel word written to the database.
REQ-002 SHALL have parameter picture_size, default 28, side of the network input image.
REQ-003 SHALL have parameter DS, default 4, power-of-2 downsample factor; source frame side is picture_size*DS (112).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port pix_valid, input, 1, source pixel qualifier; gaps allowed.
REQ-007 SHALL have port pix_sof, input, 1, first pixel of frame, meaningful only with pix_valid.
REQ-008 SHALL have port pix_data, input, 8, unsigned grayscale pixel, raster order.
REQ-009 SHALL have port STOP, input, 1, network done flag; 0 while running, 1 when RESULT valid.
REQ-010 SHALL have port we_database, output, 1, database write strobe.
REQ-011 SHALL have port dp_database, output, SIZE_1, signed pixel word.
REQ-012 SHALL have port address_p_database, output, 13, database word address.
REQ-013 SHALL have port GO, output, 1, one-cycle network start pulse.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port frames_dropped, output, 8, saturating count of frames discarded.

Function
REQ-016 SHALL implement states IDLE, CAPTURE, START, RUN.
REQ-017 IDLE->CAPTURE on pix_valid&pix_sof; that pixel is source (row 0, col 0).
REQ-018 SHALL keep source col/row counters advanced per valid pixel; col wraps at picture_size*DS-1 and increments row.
REQ-019 SHALL hold picture_size accumulators of width 8+2*log2(DS) (12 bits), indexed col/DS, cleared at start of each DS-row band.
REQ-020 When pixel at (row%DS==DS-1, col%DS==DS-1) is accepted, SHALL assert we_database exactly one cycle later with address (row/DS)*picture_size+col/DS.
REQ-021 dp_database SHALL be the completed block sum >> 2*log2(DS), zero-extended to SIZE_1 (range 0..255, always non-negative).
REQ-022 After write of address picture_size^2-1 (783), CAPTURE->START; pixels after that are ignored until next IDLE.
REQ-023 START SHALL assert GO for exactly one cycle, then enter RUN; we_database is 0 in START and RUN.
REQ-024 RUN SHALL return to IDLE only after STOP has been sampled 0 and later sampled 1 (seen-low flag), preventing exit on stale STOP.
REQ-025 pix_sof in CAPTURE SHALL restart capture at (0,0) with accumulators cleared; frames_dropped +1 (saturate at 255).
REQ-026 pix_sof in START or RUN SHALL be ignored and counted in frames_dropped.
REQ-027 pix_valid=0 cycles SHALL stall counters and accumulators with no other effect.
REQ-028 Outputs SHALL be registered; address_p_database and dp_database hold last value when we_database=0.

Reset
REQ-029 rst SHALL force IDLE, clear counters, accumulators, seen-low flag; we_database=0, GO=0, busy=0, dp_database=0, address_p_database=0, frames_dropped=0.
REQ-030 rst mid-CAPTURE or mid-RUN SHALL abandon the frame without a GO pulse; rst has priority over all inputs.

Configuration
REQ-031 Macro IMAGE_LOADER_INVERT_EN: when defined, dp_database SHALL be 255 minus the averaged value (white-on-black MNIST polarity); when undefined, averaged value is written unmodified.

Verification
REQ-032 Frame of all pixels 200, no gaps -> 784 writes, addresses 0..783 in order, dp=200 (55 with invert), one GO pulse one cycle after the last write.
REQ-033 Block (0,0) pixels 0..15 as 0,16,...,240 -> address 0 dp=120; written one cycle after source pixel (3,3).
REQ-034 pix_valid toggling 1/0 every cycle -> same data/addresses as REQ-032, write rate halved.
REQ-035 sof at source pixel 5000 of frame 1 -> frames_dropped=1, writes restart at address 0, exactly one GO after the new frame completes.
REQ-036 After GO, STOP held 1 for 3 cycles then 0 for 10 then 1 -> busy stays 1 until STOP returns 1, then IDLE; sof during RUN increments frames_dropped, no writes.
REQ-037 rst asserted at address 400 -> all outputs reset next cycle, no GO; following full frame behaves as REQ-032.
